// File: rtl/regfile_arb_pkg.sv
// Shared definitions for the register-file port arbiter: register-file
// geometry and the lock-state encoding used by the read-modify-write lock.
package regfile_arb_pkg;

    // Geometry of the CPU register file this arbiter fronts.
    localparam int RF_DW    = 16;
    localparam int RF_AW    = 3;
    localparam int RF_DEPTH = 8;

    // Lock state: LOCKED reserves both ports for a single agent until
    // that agent completes its write.
    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_t;

endpackage : regfile_arb_pkg

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: grants the first requester found at
// or after ptr, wrapping modulo N. Purely combinational; the caller owns
// the pointer register and decides when it advances.
module rr_arbiter #(
    parameter int N  = 3,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    // Scan the N candidates starting at ptr and take the first requester.
    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int k = 0; k < N; k++) begin
            int c;
            c = int'(ptr) + k;
            if (c >= N) begin
                c = c - N;
            end
            if (!any && req[c]) begin
                any    = 1'b1;
                gnt[c] = 1'b1;
                idx    = IW'(c);
            end
        end
    end

endmodule : rr_arbiter

// File: rtl/regfile_port_arbiter.sv
// Shares the single write port and single read port of the 8x16 register
// file among NAG agents. Each port is arbitrated round-robin on its own;
// a read-with-lock reserves both ports for one agent until that agent's
// write completes, giving an atomic read-modify-write.
// Optional build macro: REGFILE_ARB_BYPASS_EN -- when defined, a read and
// a write to the same register on the same edge return the new data.
module regfile_port_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int NAG = 3,
    parameter int DW  = RF_DW,
    parameter int AW  = RF_AW,
    parameter int IW  = $clog2(NAG)
) (
    input  logic              clk,
    input  logic              rst,
    // write channels
    input  logic [NAG-1:0]    wr_req,
    input  logic [NAG*AW-1:0] wr_addr,
    input  logic [NAG*DW-1:0] wr_data,
    output logic [NAG-1:0]    wr_gnt,
    // read channels
    input  logic [NAG-1:0]    rd_req,
    input  logic [NAG-1:0]    rd_lock,
    input  logic [NAG*AW-1:0] rd_addr,
    output logic [NAG-1:0]    rd_gnt,
    output logic              rd_rsp_valid,
    output logic [IW-1:0]     rd_rsp_id,
    output logic [DW-1:0]     rd_rsp_data,
    // lock status
    output logic              locked,
    output logic [IW-1:0]     lock_owner,
    // register file side
    output logic [DW-1:0]     rf_data_in,
    output logic [AW-1:0]     rf_sel_in,
    output logic              rf_write_enable,
    output logic [AW-1:0]     rf_sel_out,
    output logic              rf_output_enable,
    input  logic [DW-1:0]     rf_data_out
);

    // ------------------------------------------------------------------
    // Per-agent views of the flattened channel buses
    // ------------------------------------------------------------------
    logic [AW-1:0] wr_addr_a [NAG];
    logic [DW-1:0] wr_data_a [NAG];
    logic [AW-1:0] rd_addr_a [NAG];

    generate
        for (genvar gi = 0; gi < NAG; gi++) begin : g_unpack
            assign wr_addr_a[gi] = wr_addr[gi*AW +: AW];
            assign wr_data_a[gi] = wr_data[gi*DW +: DW];
            assign rd_addr_a[gi] = rd_addr[gi*AW +: AW];
        end
    endgenerate

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    lock_state_t   state_q,      state_d;
    logic [IW-1:0] lock_owner_q, lock_owner_d;
    logic [IW-1:0] wr_ptr_q,     wr_ptr_d;
    logic [IW-1:0] rd_ptr_q,     rd_ptr_d;
    logic          rsp_valid_q,  rsp_valid_d;
    logic [IW-1:0] rsp_id_q,     rsp_id_d;
    logic [DW-1:0] rsp_data_q,   rsp_data_d;

    // ------------------------------------------------------------------
    // Eligibility: while locked only the owner may use either port;
    // everybody else keeps requesting and simply is not seen.
    // ------------------------------------------------------------------
    logic [NAG-1:0] owner_mask;
    logic [NAG-1:0] wr_elig;
    logic [NAG-1:0] rd_elig;

    assign owner_mask = NAG'(1) << lock_owner_q;

    // Mask both request vectors down to the lock owner when locked.
    always_comb begin
        wr_elig = wr_req;
        rd_elig = rd_req;
        if (state_q == LOCKED) begin
            wr_elig = wr_req & owner_mask;
            rd_elig = rd_req & owner_mask;
        end
    end

    // ------------------------------------------------------------------
    // Arbiters, one per port
    // ------------------------------------------------------------------
    logic [NAG-1:0] wr_arb_gnt, rd_arb_gnt;
    logic [IW-1:0]  wr_idx,     rd_idx;
    logic           wr_arb_any, rd_arb_any;
    logic           wr_fire,    rd_fire;

    rr_arbiter #(.N(NAG), .IW(IW)) u_wr_arb (
        .req (wr_elig),
        .ptr (wr_ptr_q),
        .gnt (wr_arb_gnt),
        .idx (wr_idx),
        .any (wr_arb_any)
    );

    rr_arbiter #(.N(NAG), .IW(IW)) u_rd_arb (
        .req (rd_elig),
        .ptr (rd_ptr_q),
        .gnt (rd_arb_gnt),
        .idx (rd_idx),
        .any (rd_arb_any)
    );

    // Reset suppresses every grant so the register file sees no access.
    assign wr_fire = wr_arb_any & ~rst;
    assign rd_fire = rd_arb_any & ~rst;
    assign wr_gnt  = wr_fire ? wr_arb_gnt : '0;
    assign rd_gnt  = rd_fire ? rd_arb_gnt : '0;

    // ------------------------------------------------------------------
    // Register-file drive: winner's select/data, zero when idle.
    // ------------------------------------------------------------------
    always_comb begin
        rf_data_in       = '0;
        rf_sel_in        = '0;
        rf_write_enable  = wr_fire;
        rf_sel_out       = '0;
        rf_output_enable = rd_fire;
        if (wr_fire) begin
            rf_data_in = wr_data_a[wr_idx];
            rf_sel_in  = wr_addr_a[wr_idx];
        end
        if (rd_fire) begin
            rf_sel_out = rd_addr_a[rd_idx];
        end
    end

    // ------------------------------------------------------------------
    // Read data captured at the grant edge. The register file writes at
    // that same edge, so without bypass a colliding read sees old data.
    // ------------------------------------------------------------------
    logic [DW-1:0] rsp_capture;

    // Select the value to capture into the response register.
    always_comb begin
        rsp_capture = rf_data_out;
`ifdef REGFILE_ARB_BYPASS_EN
        if (wr_fire && rd_fire && (rf_sel_in == rf_sel_out)) begin
            rsp_capture = rf_data_in;
        end
`endif
    end

    // Round-robin pointers advance past the winner only when granted.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_fire) begin
            wr_ptr_d = (wr_idx == IW'(NAG-1)) ? '0 : wr_idx + IW'(1);
        end
        if (rd_fire) begin
            rd_ptr_d = (rd_idx == IW'(NAG-1)) ? '0 : rd_idx + IW'(1);
        end
    end

    // Read response: valid for exactly the cycle after a read grant.
    always_comb begin
        rsp_valid_d = 1'b0;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        if (rd_fire) begin
            rsp_valid_d = 1'b1;
            rsp_id_d    = rd_idx;
            rsp_data_d  = rsp_capture;
        end
    end

    // Lock FSM next state: acquire on a locked read grant, release on the
    // owner's write grant. A further locked read by the owner is a no-op.
    always_comb begin
        state_d      = state_q;
        lock_owner_d = lock_owner_q;
        unique case (state_q)
            UNLOCKED: begin
                if (rd_fire && rd_lock[rd_idx]) begin
                    state_d      = LOCKED;
                    lock_owner_d = rd_idx;
                end
            end
            LOCKED: begin
                // Only the owner is eligible, so any write grant is theirs.
                if (wr_fire) begin
                    state_d      = UNLOCKED;
                    lock_owner_d = '0;
                end
            end
            default: begin
                state_d      = UNLOCKED;
                lock_owner_d = '0;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= UNLOCKED;
            lock_owner_q <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            lock_owner_q <= lock_owner_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_data_q   <= rsp_data_d;
        end
    end

    assign rd_rsp_valid = rsp_valid_q;
    assign rd_rsp_id    = rsp_id_q;
    assign rd_rsp_data  = rsp_data_q;
    assign locked       = (state_q == LOCKED);
    assign lock_owner   = lock_owner_q;

endmodule : regfile_port_arbiter

// File: tb/tb_regfile_port_arbiter.sv
// Bench for regfile_port_arbiter: directed scenarios followed by random
// traffic, every cycle checked against a behavioural model of the rules.
module tb_regfile_port_arbiter;

    localparam int NAG = 3;
    localparam int DW  = 16;
    localparam int AW  = 3;
    localparam int IW  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NAG-1:0]    wr_req, rd_req, rd_lock;
    logic [NAG*AW-1:0] wr_addr, rd_addr;
    logic [NAG*DW-1:0] wr_data;
    logic [NAG-1:0]    wr_gnt, rd_gnt;
    logic              rd_rsp_valid;
    logic [IW-1:0]     rd_rsp_id;
    logic [DW-1:0]     rd_rsp_data;
    logic              locked;
    logic [IW-1:0]     lock_owner;
    logic [DW-1:0]     rf_data_in;
    logic [AW-1:0]     rf_sel_in;
    logic              rf_write_enable;
    logic [AW-1:0]     rf_sel_out;
    logic              rf_output_enable;
    logic [DW-1:0]     rf_data_out;

    always #5 clk = ~clk;

    regfile_port_arbiter #(.NAG(NAG), .DW(DW), .AW(AW), .IW(IW)) dut (
        .clk              (clk),
        .rst              (rst),
        .wr_req           (wr_req),
        .wr_addr          (wr_addr),
        .wr_data          (wr_data),
        .wr_gnt           (wr_gnt),
        .rd_req           (rd_req),
        .rd_lock          (rd_lock),
        .rd_addr          (rd_addr),
        .rd_gnt           (rd_gnt),
        .rd_rsp_valid     (rd_rsp_valid),
        .rd_rsp_id        (rd_rsp_id),
        .rd_rsp_data      (rd_rsp_data),
        .locked           (locked),
        .lock_owner       (lock_owner),
        .rf_data_in       (rf_data_in),
        .rf_sel_in        (rf_sel_in),
        .rf_write_enable  (rf_write_enable),
        .rf_sel_out       (rf_sel_out),
        .rf_output_enable (rf_output_enable),
        .rf_data_out      (rf_data_out)
    );

    // Register file attached to the DUT: write at the edge, combinational read.
    logic [DW-1:0] tb_rf [8] = '{default: '0};
    always @(posedge clk) if (rf_write_enable) tb_rf[rf_sel_in] <= rf_data_in;
    assign rf_data_out = tb_rf[rf_sel_out];

    // Reference model state.
    int            m_wr_ptr = 0, m_rd_ptr = 0, m_owner = 0, m_id = 0;
    bit            m_locked = 0, m_vld = 0;
    logic [DW-1:0] m_data = '0;
    logic [DW-1:0] m_rf [8] = '{default: '0};

    int            n_cmp = 0, n_bad = 0;
    bit            verbose = 1;
    logic [NAG-1:0] obs_wg, obs_rg;
    logic          obs_we, obs_oe;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    // First requesting agent at or after ptr, modulo NAG; -1 if none.
    function automatic int pick(input logic [NAG-1:0] req, input int ptr);
        for (int k = 0; k < NAG; k++) begin
            int i;
            i = (ptr + k) % NAG;
            if (req[i]) return i;
        end
        return -1;
    endfunction

    // One clock: check combinational outputs, advance model, check registered outputs.
    task automatic cycle();
        logic [NAG-1:0] ew, er, eg_w, eg_r;
        int w, r, wa, ra;
        logic [DW-1:0] wd, rdat;
        @(negedge clk);
        ew = wr_req;
        er = rd_req;
        for (int i = 0; i < NAG; i++) begin
            if (m_locked && i != m_owner) begin
                ew[i] = 1'b0;
                er[i] = 1'b0;
            end
        end
        w = rst ? -1 : pick(ew, m_wr_ptr);
        r = rst ? -1 : pick(er, m_rd_ptr);
        eg_w = '0;
        eg_r = '0;
        wa = 0; ra = 0; wd = '0;
        if (w >= 0) begin
            eg_w[w] = 1'b1;
            wa = int'(wr_addr[w*AW +: AW]);
            wd = wr_data[w*DW +: DW];
        end
        if (r >= 0) begin
            eg_r[r] = 1'b1;
            ra = int'(rd_addr[r*AW +: AW]);
        end
        obs_wg = wr_gnt; obs_rg = rd_gnt;
        obs_we = rf_write_enable; obs_oe = rf_output_enable;
        chk("wr_gnt",  32'(wr_gnt), 32'(eg_w));
        chk("rd_gnt",  32'(rd_gnt), 32'(eg_r));
        chk("rf_we",   32'(rf_write_enable), 32'(w >= 0));
        chk("rf_oe",   32'(rf_output_enable), 32'(r >= 0));
        chk("sel_in",  32'(rf_sel_in), 32'(wa));
        chk("data_in", 32'(rf_data_in), 32'(wd));
        chk("sel_out", 32'(rf_sel_out), 32'(ra));
        if (rst) begin
            m_wr_ptr = 0; m_rd_ptr = 0; m_locked = 0; m_owner = 0;
            m_vld = 0; m_id = 0; m_data = '0;
        end else begin
            if (r >= 0) begin
                rdat = m_rf[ra];
`ifdef REGFILE_ARB_BYPASS_EN
                if (w >= 0 && wa == ra) rdat = wd;
`endif
                m_vld = 1; m_id = r; m_data = rdat;
                m_rd_ptr = (r + 1) % NAG;
            end else begin
                m_vld = 0;
            end
            if (!m_locked) begin
                if (r >= 0 && rd_lock[r]) begin
                    m_locked = 1; m_owner = r;
                end
            end else if (w >= 0) begin
                m_locked = 0; m_owner = 0;
            end
            if (w >= 0) begin
                m_rf[wa] = wd;
                m_wr_ptr = (w + 1) % NAG;
            end
        end
        @(posedge clk);
        #1;
        chk("rsp_valid",  32'(rd_rsp_valid), 32'(m_vld));
        chk("rsp_id",     32'(rd_rsp_id), 32'(m_id));
        chk("rsp_data",   32'(rd_rsp_data), 32'(m_data));
        chk("locked",     32'(locked), 32'(m_locked));
        chk("lock_owner", 32'(lock_owner), 32'(m_owner));
        if (verbose)
            $display("t=%0t rst=%0d wr_gnt=%b rd_gnt=%b rsp_v=%0d id=%0d data=%h locked=%0d owner=%0d",
                     $time, rst, obs_wg, obs_rg, rd_rsp_valid, rd_rsp_id, rd_rsp_data, locked, lock_owner);
        // Agents drop a request once it has been granted.
        wr_req = wr_req & ~eg_w;
        rd_req = rd_req & ~eg_r;
    endtask

    task automatic set_wr(input int i, input int a, input int d);
        wr_req[i] = 1'b1;
        wr_addr[i*AW +: AW] = AW'(a);
        wr_data[i*DW +: DW] = DW'(d);
    endtask

    task automatic set_rd(input int i, input int a, input bit lk);
        rd_req[i] = 1'b1;
        rd_lock[i] = lk;
        rd_addr[i*AW +: AW] = AW'(a);
    endtask

    task automatic new_reqs();
        for (int i = 0; i < NAG; i++) begin
            if (!wr_req[i] && $urandom_range(0, 99) < 35)
                set_wr(i, int'($urandom_range(0, 7)), int'($urandom_range(0, 16'hFFFF)));
            if (!rd_req[i] && $urandom_range(0, 99) < 35)
                set_rd(i, int'($urandom_range(0, 7)), $urandom_range(0, 99) < 20);
        end
        rst = ($urandom_range(0, 299) == 0);
    endtask

    initial begin
        rst = 1'b1;
        wr_req = '0; rd_req = '0; rd_lock = '0;
        wr_addr = '0; rd_addr = '0; wr_data = '0;
        cycle();
        cycle();
        rst = 1'b0;
        chk("reset_locked", 32'(locked), 32'h0);
        chk("reset_valid",  32'(rd_rsp_valid), 32'h0);
        chk("reset_data",   32'(rd_rsp_data), 32'h0);

        // Contention on the write port.
        set_wr(0, 1, 16'h1111); set_wr(1, 2, 16'h2222); set_wr(2, 3, 16'h3333);
        cycle(); chk("cont_g0", 32'(obs_wg), 32'b001);
        cycle(); chk("cont_g1", 32'(obs_wg), 32'b010);
        cycle(); chk("cont_g2", 32'(obs_wg), 32'b100);
        set_rd(0, 1, 0); set_rd(1, 2, 0); set_rd(2, 3, 0);
        cycle(); chk("cont_rd0", 32'(rd_rsp_data), 32'h1111);
        cycle(); chk("cont_rd1", 32'(rd_rsp_data), 32'h2222);
        cycle(); chk("cont_rd2", 32'(rd_rsp_data), 32'h3333);

        // Read latency.
        set_rd(1, 2, 0);
        cycle();
        chk("lat_gnt",  32'(obs_rg), 32'b010);
        chk("lat_vld",  32'(rd_rsp_valid), 32'h1);
        chk("lat_id",   32'(rd_rsp_id), 32'h1);
        chk("lat_data", 32'(rd_rsp_data), 32'h2222);
        cycle();
        chk("lat_vld_off", 32'(rd_rsp_valid), 32'h0);

        // Lock: agent0 locked read of r4, agent2 write waits.
        set_rd(0, 4, 1);
        cycle();
        chk("lock_set", 32'(locked), 32'h1);
        chk("lock_own", 32'(lock_owner), 32'h0);
        set_wr(2, 6, 16'h6666); set_rd(1, 7, 0);
        cycle();
        chk("lock_blk_wr", 32'(obs_wg), 32'b000);
        chk("lock_blk_rd", 32'(obs_rg), 32'b000);
        chk("lock_hold", 32'(locked), 32'h1);
        rd_lock[0] = 1'b0;
        set_wr(0, 4, 16'h0005);
        cycle();
        chk("lock_owner_wr", 32'(obs_wg), 32'b001);
        chk("lock_release", 32'(locked), 32'h0);
        cycle();
        chk("lock_after_wr", 32'(obs_wg), 32'b100);
        chk("lock_after_rd", 32'(obs_rg), 32'b010);

        // Same-register collision.
        set_wr(1, 5, 16'hBEEF); set_rd(2, 5, 0);
        cycle();
`ifdef REGFILE_ARB_BYPASS_EN
        chk("collide", 32'(rd_rsp_data), 32'hBEEF);
`else
        chk("collide", 32'(rd_rsp_data), 32'h0000);
`endif

        // Reset while locked with a response pending.
        set_rd(0, 1, 1);
        cycle();
        chk("rl_locked", 32'(locked), 32'h1);
        chk("rl_pending", 32'(rd_rsp_valid), 32'h1);
        set_wr(1, 2, 16'h7777);
        rst = 1'b1;
        cycle();
        chk("rl_wg", 32'(obs_wg), 32'h0);
        chk("rl_rg", 32'(obs_rg), 32'h0);
        chk("rl_we", 32'(obs_we), 32'h0);
        chk("rl_oe", 32'(obs_oe), 32'h0);
        chk("rl_unlock", 32'(locked), 32'h0);
        chk("rl_drop", 32'(rd_rsp_valid), 32'h0);
        rst = 1'b0;
        rd_lock = '0;
        set_wr(0, 1, 16'h00A1); set_wr(1, 2, 16'h00A2); set_wr(2, 3, 16'h00A3);
        set_rd(0, 1, 0); set_rd(1, 2, 0); set_rd(2, 3, 0);
        cycle();
        chk("rl_restart_wr", 32'(obs_wg), 32'b001);
        chk("rl_restart_rd", 32'(obs_rg), 32'b001);
        cycle();
        cycle();

        // Idle: nothing requested, pointers must stay put.
        for (int n = 0; n < 10; n++) begin
            cycle();
            chk("idle_we", 32'(obs_we), 32'h0);
            chk("idle_oe", 32'(obs_oe), 32'h0);
        end
        set_wr(0, 0, 16'h0A0A); set_wr(1, 6, 16'h0B0B); set_wr(2, 7, 16'h0C0C);
        set_rd(0, 1, 0); set_rd(1, 2, 0); set_rd(2, 3, 0);
        cycle();
        chk("idle_ptr_wr", 32'(obs_wg), 32'b001);
        chk("idle_ptr_rd", 32'(obs_rg), 32'b001);
        cycle();
        cycle();

        // Random traffic against the model.
        verbose = 0;
        for (int n = 0; n < 3000; n++) begin
            new_reqs();
            cycle();
        end
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_regfile_port_arbiter

// File: doc/regfile_port_arbiter.md
Name: regfile_port_arbiter

Overview:
- Shares the single write port and single read port of the 8x16-bit CPU register file among NAG agents, e.g. fetch/decode, ALU writeback and load unit.
- Each agent owns one read channel and one write channel.
- Each port is arbitrated round-robin, independently of the other.
- A read-with-lock reserves both ports for one agent until it completes its write, which gives atomic read-modify-write.
- Sits between the agents and the register file, and drives its data_in, sel_in, sel_out, write_enable and output_enable.

Parameters:
- NAG, 3, number of agents; legal range 2..8.
- DW, 16, register width.
- AW, 3, register select width (8 registers).
- IW, $clog2(NAG), agent id width.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous active-high reset.
- wr_req  in  NAG  write request per agent; held until granted.
- wr_addr  in  NAG*AW  write register select, agent i at [i*AW +: AW].
- wr_data  in  NAG*DW  write data, agent i at [i*DW +: DW].
- wr_gnt  out  NAG  one-hot write grant; combinational; the write completes at this edge.
- rd_req  in  NAG  read request per agent; held until granted.
- rd_lock  in  NAG  qualifies rd_req as lock-acquiring.
- rd_addr  in  NAG*AW  read register select.
- rd_gnt  out  NAG  one-hot read grant; combinational.
- rd_rsp_valid  out  1  read data valid; one cycle after grant.
- rd_rsp_id  out  IW  agent that owns the response.
- rd_rsp_data  out  DW  registered read data.
- locked  out  1  lock FSM is in the LOCKED state.
- lock_owner  out  IW  current lock owner; 0 when unlocked.
- rf_data_in  out  DW  to regfile data_in.
- rf_sel_in  out  AW  to regfile sel_in.
- rf_write_enable  out  1  to regfile write_enable.
- rf_sel_out  out  AW  to regfile sel_out.
- rf_output_enable  out  1  to regfile output_enable.
- rf_data_out  in  DW  from regfile data_out; combinational read.

Behaviour:
- Reset values:
  - wr_ptr=0, rd_ptr=0.
  - FSM=UNLOCKED, lock_owner=0.
  - rd_rsp_valid=0, rd_rsp_id=0, rd_rsp_data=0.
  - While rst is high, grants are forced to 0, so rf_write_enable=0 and rf_output_enable=0.
- Write port arbitration:
  - Eligible set is wr_req, masked by the lock rule below.
  - Winner is the first eligible index at or after wr_ptr, wrapping modulo NAG.
  - wr_gnt = onehot(winner). rf_write_enable = |wr_gnt.
  - rf_sel_in and rf_data_in are muxed from the winner.
  - When no grant is issued, rf_sel_in and rf_data_in are 0.
  - After a grant, wr_ptr = winner+1, wrapping NAG-1 to 0. With no grant, wr_ptr holds.
- Read port arbitration:
  - Same scheme with rd_ptr and rd_gnt. rf_output_enable = |rd_gnt; rf_sel_out = winner's rd_addr.
  - On a granted edge: rd_rsp_data <= rf_data_out, rd_rsp_id <= winner, rd_rsp_valid <= 1.
  - Otherwise rd_rsp_valid <= 0, and rd_rsp_data / rd_rsp_id hold.
  - Read latency is exactly 1 cycle and there is no backpressure.
- Fairness: each requesting agent is granted within NAG cycles on each port, provided the port is unlocked.
- Lock FSM:
  - UNLOCKED -> LOCKED when agent i is read-granted with rd_lock[i]=1; lock_owner <= i.
  - While LOCKED, only lock_owner is eligible on both ports. Other agents' requests stay pending and their pointers do not advance.
  - LOCKED -> UNLOCKED on the edge where lock_owner is write-granted.
  - A locked read by the owner while LOCKED keeps the state LOCKED; it does not nest.
- Simultaneous read and write to the same register with no bypass: the read returns the old value, because the register file writes at the edge.
- Reset mid-operation: a pending response is dropped (rd_rsp_valid=0) and the lock is released.

Optional Feature:
- REGFILE_ARB_BYPASS_EN defined: when rf_write_enable and rf_output_enable are both asserted and rf_sel_in==rf_sel_out, the captured rd_rsp_data is rf_data_in (new value). Adds one comparator and one mux.
- Macro undefined: rd_rsp_data is always rf_data_out (old value).

Decomposition:
- Package regfile_arb_pkg holds:
  - the lock-state typedef {UNLOCKED, LOCKED};
  - RF_DW=16, RF_AW=3, RF_DEPTH=8.
- One sub-module, rr_arbiter (params N). Inputs: req, ptr. Outputs: gnt one-hot, idx, any.
- rr_arbiter is instantiated twice, once for the write port and once for the read port.

Test Plan:
- Contention: NAG=3; wr_req=3'b111 with addr/data agent0 r1/0x1111, agent1 r2/0x2222, agent2 r3/0x3333.
  - Required grants: 001, 010, 100 on consecutive cycles.
  - Then reading r1, r2, r3 returns 0x1111, 0x2222, 0x3333.
- Read latency: agent1 reads r2 at cycle N.
  - Required: rd_gnt=010 at N; at N+1, rd_rsp_valid=1, rd_rsp_id=1, rd_rsp_data=0x2222.
  - rd_rsp_valid=0 at N+2 if there is no new request.
- Lock: agent0 locked-reads r4 while agent2 holds wr_req; agent0 then writes r4=0x0005 two cycles later.
  - Required: agent2 is not granted while locked=1; locked=1 and lock_owner=0.
  - After agent0's write edge: locked=0, and agent2 is granted the next cycle.
- Same-register collision: write r5=0xBEEF and read r5 in the same cycle, with r5 previously 0x0000.
  - Without the macro: response is 0x0000. With REGFILE_ARB_BYPASS_EN: response is 0xBEEF.
- Reset mid-lock: assert rst for 1 cycle while locked=1 and a response is pending.
  - Required next cycle: locked=0, rd_rsp_valid=0, all grants 0 during rst.
  - Arbitration restarts from agent0.
- Idle: no requests for 10 cycles.
  - Required: rf_write_enable=0, rf_output_enable=0, pointers unchanged.
